// File: rtl/lsu_mem_initiator_pkg.sv
// Shared definitions for the LSU data-memory initiator: memory part encodings,
// RV32I load/store funct3 values, FSM states and request classification helpers.
package lsu_mem_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // How a legal request is carried out on the memory port
  typedef enum logic [1:0] {
    PLAN_NATIVE   = 2'd0,  // single access with native size
    PLAN_LD_SPLIT = 2'd1,  // two aligned word reads, reassembled
    PLAN_ST_SPLIT = 2'd2   // ascending byte writes
  } plan_e;

  // read_part encodings understood by the data memory
  localparam logic [2:0] RP_WORD   = 3'd0;
  localparam logic [2:0] RP_HALF_S = 3'd1;
  localparam logic [2:0] RP_HALF_U = 3'd2;
  localparam logic [2:0] RP_BYTE_S = 3'd3;
  localparam logic [2:0] RP_BYTE_U = 3'd4;

  // write_part encodings understood by the data memory
  localparam logic [1:0] WP_WORD = 2'd0;
  localparam logic [1:0] WP_HALF = 2'd1;
  localparam logic [1:0] WP_BYTE = 2'd2;

  // RV32I load/store funct3 values (stores use only B/H/W)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Halves must sit on even addresses and words on multiples of four
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [2:0] native_rp(input logic [2:0] f3);
    logic [2:0] rp;
    case (f3)
      F3_B:    rp = RP_BYTE_S;
      F3_BU:   rp = RP_BYTE_U;
      F3_H:    rp = RP_HALF_S;
      F3_HU:   rp = RP_HALF_U;
      default: rp = RP_WORD;
    endcase
    return rp;
  endfunction

  function automatic logic [1:0] native_wp(input logic [2:0] f3);
    logic [1:0] wp;
    case (f3[1:0])
      2'b00:   wp = WP_BYTE;
      2'b01:   wp = WP_HALF;
      default: wp = WP_WORD;
    endcase
    return wp;
  endfunction

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// Pipeline request/response handshake plus the data-memory port of the LSU.
// master = the LSU initiator; slave = the pipeline/memory environment.
interface lsu_mem_initiator_if #(parameter int ADDR_W = 8) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [2:0]        read_part;
  logic [1:0]        write_part;
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] address;
  logic [31:0]       data_in;
  logic [31:0]       data_out;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, data_out,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output read_part, write_part, MemRead, MemWrite, address, data_in
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, data_out,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  read_part, write_part, MemRead, MemWrite, address, data_in
  );
endinterface

// File: rtl/lsu_load_align.sv
// Load data reassembly: picks the addressed bytes out of two consecutive
// memory words and sign- or zero-extends them according to funct3.
module lsu_load_align
  import lsu_mem_initiator_pkg::*;
(
  input  logic [31:0] w0_i,
  input  logic [31:0] w1_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] rdata_o
);

  logic [63:0] shifted_s;

  // Shift the little-endian word pair down to the offset, then size/extend
  always_comb begin
    shifted_s = {w1_i, w0_i} >> {offset_i, 3'b000};
    case (funct3_i)
      F3_B:    rdata_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_BU:   rdata_o = {24'd0, shifted_s[7:0]};
      F3_H:    rdata_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_HU:   rdata_o = {16'd0, shifted_s[15:0]};
      default: rdata_o = shifted_s[31:0];
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// LSU data-memory initiator: accepts one load/store at a time, splits
// misaligned accesses into native memory accesses and returns a one-cycle
// response pulse. All bus outputs are registered; MemWrite is additionally
// gated by rst so a reset cycle never commits a byte.
module lsu_mem_initiator
  import lsu_mem_initiator_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter bit MISALIGN_EN = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  lsu_mem_initiator_if.master  bus
);

  state_e            state_q, state_d;
  plan_e             plan_q, plan_d, in_plan_s, acc_plan_s;
  logic [1:0]        k_q, k_d, last_q, last_d, in_last_s, acc_j_s;
  logic              we_q, we_d, in_mis_s, in_err_s;
  logic [2:0]        f3_q, f3_d, acc_f3_s;
  logic [ADDR_W-1:0] addr_q, addr_d, acc_base_s, acc_addr_s;
  logic [31:0]       wdata_q, wdata_d, acc_wdata_s, acc_din_s, acc_shift_s;
  logic [31:0]       buf0_q, buf0_d, align_w0_s, align_rdata_s;
  logic [2:0]        acc_rp_s;
  logic [1:0]        acc_wp_s;
  logic              req_ready_q, req_ready_d, resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d, data_in_q, data_in_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [2:0]        read_part_q, read_part_d;
  logic [1:0]        write_part_q, write_part_d;

  // Classify the incoming request: legality, alignment, plan and last access index
  always_comb begin
    in_mis_s  = is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
    in_err_s  = ~f3_legal(bus.req_we, bus.req_funct3) | (in_mis_s & ~MISALIGN_EN);
    in_plan_s = PLAN_NATIVE;
    in_last_s = 2'd0;
    if (in_mis_s) begin
      if (bus.req_we) begin
        in_plan_s = PLAN_ST_SPLIT;
        in_last_s = (bus.req_funct3[1:0] == 2'b01) ? 2'd1 : 2'd3;
      end else begin
        in_plan_s = PLAN_LD_SPLIT;
        in_last_s = 2'd1;
      end
    end else begin
      in_plan_s = PLAN_NATIVE;
    end
  end

  // Choose which access to prepare next: access 0 of a new request, or k+1 of the current one
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_j_s     = 2'd0;
      acc_plan_s  = in_plan_s;
      acc_base_s  = bus.req_addr;
      acc_wdata_s = bus.req_wdata;
      acc_f3_s    = bus.req_funct3;
    end else begin
      acc_j_s     = k_q + 2'd1;
      acc_plan_s  = plan_q;
      acc_base_s  = addr_q;
      acc_wdata_s = wdata_q;
      acc_f3_s    = f3_q;
    end
  end

  // Address, part encodings and write data of access j under the chosen plan
  always_comb begin
    acc_shift_s = acc_wdata_s >> {acc_j_s, 3'b000};
    case (acc_plan_s)
      PLAN_LD_SPLIT: begin
        acc_addr_s = {acc_base_s[ADDR_W-1:2], 2'b00} + (acc_j_s[0] ? ADDR_W'(3'd4) : ADDR_W'(1'b0));
        acc_rp_s   = RP_WORD;
        acc_wp_s   = WP_WORD;
        acc_din_s  = acc_wdata_s;
      end
      PLAN_ST_SPLIT: begin
        acc_addr_s = acc_base_s + ADDR_W'(acc_j_s);
        acc_rp_s   = RP_WORD;
        acc_wp_s   = WP_BYTE;
        acc_din_s  = {24'd0, acc_shift_s[7:0]};
      end
      default: begin
        acc_addr_s = acc_base_s;
        acc_rp_s   = native_rp(acc_f3_s);
        acc_wp_s   = native_wp(acc_f3_s);
        acc_din_s  = acc_wdata_s;
      end
    endcase
  end

  // The final word is still on data_out at the last access edge, so bypass it into the aligner
  always_comb begin
    align_w0_s = (k_q == 2'd0) ? bus.data_out : buf0_q;
  end

  lsu_load_align u_align (
    .w0_i     (align_w0_s),
    .w1_i     (bus.data_out),
    .offset_i ((plan_q == PLAN_LD_SPLIT) ? addr_q[1:0] : 2'b00),
    .funct3_i (f3_q),
    .rdata_o  (align_rdata_s)
  );

  // FSM next state and next values of all registered outputs
  always_comb begin
    state_d      = state_q;
    plan_d       = plan_q;
    k_d          = k_q;
    last_d       = last_q;
    we_d         = we_q;
    f3_d         = f3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    buf0_d       = buf0_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    address_d    = address_q;
    data_in_d    = data_in_q;
    read_part_d  = read_part_q;
    write_part_d = write_part_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          plan_d  = in_plan_s;
          last_d  = in_last_s;
          k_d     = 2'd0;
          if (in_err_s) begin
            state_d      = ST_DONE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'd0;
          end else begin
            state_d      = ST_ACC;
            mem_read_d   = ~bus.req_we;
            mem_write_d  = bus.req_we;
            address_d    = acc_addr_s;
            read_part_d  = acc_rp_s;
            write_part_d = acc_wp_s;
            data_in_d    = acc_din_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (!we_q && (k_q == 2'd0)) begin
          buf0_d = bus.data_out;
        end else begin
          buf0_d = buf0_q;
        end
        if (k_q == last_q) begin
          state_d      = ST_DONE;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = we_q ? 32'd0 : align_rdata_s;
        end else begin
          k_d          = k_q + 2'd1;
          mem_read_d   = ~we_q;
          mem_write_d  = we_q;
          address_d    = acc_addr_s;
          read_part_d  = acc_rp_s;
          write_part_d = acc_wp_s;
          data_in_d    = acc_din_s;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    req_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      plan_q       <= PLAN_NATIVE;
      k_q          <= 2'd0;
      last_q       <= 2'd0;
      we_q         <= 1'b0;
      f3_q         <= 3'd0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      buf0_q       <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      address_q    <= '0;
      data_in_q    <= 32'd0;
      read_part_q  <= 3'd0;
      write_part_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      plan_q       <= plan_d;
      k_q          <= k_d;
      last_q       <= last_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      buf0_q       <= buf0_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      address_q    <= address_d;
      data_in_q    <= data_in_d;
      read_part_q  <= read_part_d;
      write_part_q <= write_part_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.MemRead    = mem_read_q;
  assign bus.MemWrite   = mem_write_q & ~rst;
  assign bus.address    = address_q;
  assign bus.data_in    = data_in_q;
  assign bus.read_part  = read_part_q;
  assign bus.write_part = write_part_q;

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
Initiator side of the data-memory port. It takes RV32I load/store requests from the pipeline's MEM stage and drives the data memory's interface: read_part, write_part, MemRead, MemWrite, byte address, data_in and data_out. Misaligned accesses are split into several native memory accesses, and loaded data is reassembled and extended. The block stalls the pipeline through a valid/ready handshake.

Parameters:
ADDR_W, 8, byte-address width; addresses wrap modulo 2^ADDR_W.
MISALIGN_EN, 1, 1 = split misaligned accesses; 0 = report them as errors with no memory access.

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3 (load: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; store: 000 sb, 001 sh, 010 sw)
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result; 0 for stores and errors
resp_err  out  1  illegal funct3, or misaligned access with MISALIGN_EN=0
read_part  out  3  to memory: 0 word, 1 half signed, 2 half unsigned, 3 byte signed, 4 byte unsigned
write_part  out  2  to memory: 0 word, 1 half, 2 byte
MemRead  out  1  memory read enable
MemWrite  out  1  memory write enable; memory commits on negedge clk
address  out  ADDR_W  memory byte address
data_in  out  32  memory write data
data_out  in  32  memory read data; combinational, valid in the same cycle

Behaviour:
- Reset values:
  - state=IDLE, req_ready=1.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - MemRead=0, MemWrite=0, address=0, data_in=0, read_part=0, write_part=0.
- States: IDLE -> ACC -> DONE -> IDLE. Access counter k runs 0..n-1 and is held in a 2-bit register; n is the access count.
- IDLE:
  - req_ready=1.
  - On req_valid: latch the request and compute n and the access plan.
  - Illegal funct3 (load 011/110/111; store >=011): go to DONE with err=1 and n=0.
  - Otherwise go to ACC with k=0.
- Access plan (offset o = addr[1:0]; alignment rules are fixed by the memory):
  - Aligned (byte; half with o in {0,2}; word with o=0): n=1, native read_part/write_part at req_addr.
  - Misaligned load (half with o in {1,3}; word with o!=0): n=2.
    - Two word reads (read_part=0) at A0={addr[7:2],00} and A1=A0+4, mod 256.
    - Result = ({w1,w0} >> 8*o), truncated to size and sign- or zero-extended per funct3.
  - Misaligned store: n = 2 (half) or 4 (word) byte writes (write_part=2).
    - Byte i goes to addr+i (mod 256) with data_in={24'b0, wdata[8i+7:8i]}.
    - Bytes are written in ascending order.
  - With MISALIGN_EN=0, any misaligned access goes to DONE with err=1.
- ACC:
  - Drive access k. MemRead=~we; MemWrite=we & ~rst.
  - Loads sample data_out into word buffer k at posedge.
  - At k=n-1, go to DONE.
- DONE:
  - resp_valid=1 for exactly one cycle; resp_rdata and resp_err come from registers.
  - MemRead=MemWrite=0. Return to IDLE.
- Latency from the acceptance cycle c0: resp_valid in c(1+n+... ) as follows — aligned c2; misaligned load c3; misaligned half store c3; misaligned word store c5; error c1.
- Outside ACC, MemRead=MemWrite=0. Memory outputs are held at their last value when idle.
- A request is never accepted while busy. req_valid is ignored outside IDLE.
- Reset mid-operation:
  - MemWrite is gated combinationally by rst, so no byte is written in the reset cycle.
  - Bytes already committed stay written; a partial store is allowed.
  - req_ready=1 on the cycle after reset; no resp_valid pulse is issued.

Decomposition:
- Shared package: read_part/write_part encodings, RV32I load/store funct3 constants, and the state enum.
- One sub-module, lsu_load_align: combinational. Inputs are the two buffered words, the offset and funct3; output is the 32-bit extended result. It is reusable by the pipeline's forwarding path.

Test Plan:
1. sw 0x11223344 @0x10, then lw @0x10 -> one MemWrite cycle (write_part=0); resp_valid at c2 for both; rdata=0x11223344.
2. Memory [0x10]=0x11223344, [0x14]=0xAABBCCDD; lw @0x11 -> two reads at 0x10/0x14; rdata=0xDD112233 at c3.
3. Same memory; lh @0x13 -> rdata=0xFFFFDD11; lhu @0x13 -> rdata=0x0000DD11.
4. sw 0xCAFEBABE @0xFE -> four byte writes at 0xFE, 0xFF, 0x00, 0x01 with bytes BE, BA, FE, CA; resp at c5; lw @0x00 afterwards shows the low half = 0xCAFE.
5. Load with funct3=011 -> resp_valid at c1, resp_err=1, rdata=0; MemRead never asserted.
6. Misaligned sw @0x21, rst asserted during the third ACC cycle -> only bytes 0x21 and 0x22 are changed; no resp_valid; req_ready=1 on the next cycle.
